mask_cndt_seq: RTL and testbench

//  Sequential, parametrised condition-mask unit for the prz core. Holds NUM_FSETS

---
 rtl/mask_cndt_pkg.sv | 39 +++
 rtl/mask_cndt_seq_cond_eval.sv | 36 +++
 rtl/mask_cndt_seq.sv | 118 +++++++++++
 tb/tb_mask_cndt_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mask_cndt_pkg.sv
// Shared constants and types for the condition-mask unit.
package mask_cndt_pkg;

    // Condition codes; bit 3 inverts the sense of codes 0..7.
    localparam logic [3:0] CC_TRUE  = 4'h0;
    localparam logic [3:0] CC_LE    = 4'h1;
    localparam logic [3:0] CC_C     = 4'h2;
    localparam logic [3:0] CC_OVR   = 4'h3;
    localparam logic [3:0] CC_NEG   = 4'h4;
    localparam logic [3:0] CC_Z     = 4'h5;
    localparam logic [3:0] CC_POS   = 4'h6;
    localparam logic [3:0] CC_GE    = 4'h7;
    localparam logic [3:0] CC_FALSE = 4'h8;
    localparam logic [3:0] CC_GT    = 4'h9;
    localparam logic [3:0] CC_NC    = 4'hA;
    localparam logic [3:0] CC_NOVR  = 4'hB;
    localparam logic [3:0] CC_NNEG  = 4'hC;
    localparam logic [3:0] CC_NZ    = 4'hD;
    localparam logic [3:0] CC_NPOS  = 4'hE;
    localparam logic [3:0] CC_LT    = 4'hF;

    // Bit positions inside a 4-bit flag vector {Z,S,C,OVR}.
    localparam int FLG_Z   = 3;
    localparam int FLG_S   = 2;
    localparam int FLG_C   = 1;
    localparam int FLG_OVR = 0;

    // Registered result handed to the jump/PC logic.
    typedef struct packed {
        logic       mask;
        logic [3:0] cond;
    } mask_rsp_t;

    // Bank-select width; at least one bit even for a single bank.
    function automatic int fsw_calc(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mask_cndt_seq_cond_eval.sv
// Combinational condition evaluator: condition code + flags -> mask bit.
module cond_eval
    import mask_cndt_pkg::*;
(
    input  logic [3:0] cc,
    input  logic [3:0] flags,
    output logic       mask
);

    logic z, s, c, ovr, v, base;

    assign z   = flags[FLG_Z];
    assign s   = flags[FLG_S];
    assign c   = flags[FLG_C];
    assign ovr = flags[FLG_OVR];
    assign v   = ovr ^ s;

    // Decode the positive-sense condition; cc[3] selects its inverse.
    always_comb begin
        base = 1'b0;
        case (cc[2:0])
            CC_TRUE[2:0]: base = 1'b1;
            CC_LE[2:0]:   base = z | v;
            CC_C[2:0]:    base = c;
            CC_OVR[2:0]:  base = ovr;
            CC_NEG[2:0]:  base = s;
            CC_Z[2:0]:    base = z;
            CC_POS[2:0]:  base = ~(s | z);
            CC_GE[2:0]:   base = ~v;
            default:      base = 1'b0;
        endcase
    end

    assign mask = base ^ cc[3];

endmodule

// File: rtl/mask_cndt_seq.sv
// Banked flag registers, condition evaluation and a 1-deep valid/ready
// result register feeding the jump logic, plus saturating statistics.
module mask_cndt_seq
    import mask_cndt_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int COND_LSB    = 0,
    parameter int NUM_FSETS   = 2,
    parameter int FWD_EN      = 1,
    parameter int CNT_WIDTH   = 16,
    localparam int FSW        = fsw_calc(NUM_FSETS)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flag_we_i,
    input  logic [FSW-1:0]         flag_wsel_i,
    input  logic                   z_flag_i,
    input  logic                   s_flag_i,
    input  logic                   c_flag_i,
    input  logic                   ovr_flag_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   instr_valid_i,
    input  logic [FSW-1:0]         fset_sel_i,
    output logic                   instr_ready_o,
    output logic                   mask_o,
    output logic [3:0]             cond_o,
    output logic                   mask_valid_o,
    input  logic                   mask_ready_i,
    input  logic                   cnt_clr_i,
    output logic [CNT_WIDTH-1:0]   eval_cnt_o,
    output logic [CNT_WIDTH-1:0]   taken_cnt_o
);

    logic [NUM_FSETS-1:0][3:0] bank;
    logic [3:0]                wr_flags;
    logic [3:0]                bank_rd;
    logic [3:0]                ev_flags;
    logic [3:0]                cc;
    logic                      ev_mask;
    logic                      accept;
    mask_rsp_t                 rsp_q;
    logic                      unused_instr;

    assign wr_flags     = {z_flag_i, s_flag_i, c_flag_i, ovr_flag_i};
    assign cc           = instr_i[COND_LSB+3:COND_LSB];
    assign unused_instr = ^instr_i;

    assign instr_ready_o = ~mask_valid_o | mask_ready_i;
    assign accept        = instr_valid_i & instr_ready_o;

    // Bank write; selects beyond NUM_FSETS match no bank and are dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bank <= '0;
        end else begin
            for (int i = 0; i < NUM_FSETS; i++) begin
                if (flag_we_i && (flag_wsel_i == FSW'(i)))
                    bank[i] <= wr_flags;
            end
        end
    end

    // Bank read mux; an unmatched select reads as all-zero flags.
    always_comb begin
        bank_rd = '0;
        for (int i = 0; i < NUM_FSETS; i++) begin
            if (fset_sel_i == FSW'(i))
                bank_rd = bank[i];
        end
    end

    // Same-cycle write to the evaluated bank bypasses the register when enabled.
    always_comb begin
        ev_flags = bank_rd;
        if ((FWD_EN != 0) && flag_we_i && (flag_wsel_i == fset_sel_i))
            ev_flags = wr_flags;
    end

    cond_eval u_cond_eval (
        .cc    (cc),
        .flags (ev_flags),
        .mask  (ev_mask)
    );

    // Output register: load on accept, clear valid on drain-only, else hold.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rsp_q        <= '0;
            mask_valid_o <= 1'b0;
        end else if (accept) begin
            rsp_q.mask   <= ev_mask;
            rsp_q.cond   <= cc;
            mask_valid_o <= 1'b1;
        end else if (mask_ready_i) begin
            mask_valid_o <= 1'b0;
        end
    end

    assign mask_o = rsp_q.mask;
    assign cond_o = rsp_q.cond;

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            eval_cnt_o  <= '0;
            taken_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            eval_cnt_o  <= '0;
            taken_cnt_o <= '0;
        end else if (accept) begin
            if (eval_cnt_o != {CNT_WIDTH{1'b1}})
                eval_cnt_o <= eval_cnt_o + 1'b1;
            if (ev_mask && (taken_cnt_o != {CNT_WIDTH{1'b1}}))
                taken_cnt_o <= taken_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_mask_cndt_seq.sv
// Directed bench for mask_cndt_seq: two instances (bypass on/off) share the
// stimulus; a bank/queue model supplies every expected value.
module tb_mask_cndt_seq;

    localparam int NF = 3;
    localparam int CW = 4;

    logic        clk;
    logic        rst_n;
    logic        flag_we;
    logic [1:0]  flag_wsel;
    logic        z, s, c, o;
    logic [15:0] instr;
    logic        instr_valid;
    logic [1:0]  fset_sel;
    logic        mask_ready;
    logic        cnt_clr;

    logic          rdy1, mask1, mv1, rdy0, mask0, mv0;
    logic [3:0]    cond1, cond0;
    logic [CW-1:0] ev1, tk1, ev0, tk0;

    typedef struct {
        logic       m;
        logic [3:0] c;
    } exp_t;

    exp_t          q1[$];
    exp_t          q0[$];
    logic [3:0]    mbank[NF];
    logic [CW-1:0] me, mt1, mt0;
    int            checks = 0;
    int            errors = 0;

    mask_cndt_seq #(.INSTR_WIDTH(16), .COND_LSB(0), .NUM_FSETS(NF), .FWD_EN(1), .CNT_WIDTH(CW)) u_fwd (
        .clk_i(clk), .rst_n_i(rst_n), .flag_we_i(flag_we), .flag_wsel_i(flag_wsel),
        .z_flag_i(z), .s_flag_i(s), .c_flag_i(c), .ovr_flag_i(o),
        .instr_i(instr), .instr_valid_i(instr_valid), .fset_sel_i(fset_sel),
        .instr_ready_o(rdy1), .mask_o(mask1), .cond_o(cond1), .mask_valid_o(mv1),
        .mask_ready_i(mask_ready), .cnt_clr_i(cnt_clr), .eval_cnt_o(ev1), .taken_cnt_o(tk1)
    );

    mask_cndt_seq #(.INSTR_WIDTH(16), .COND_LSB(0), .NUM_FSETS(NF), .FWD_EN(0), .CNT_WIDTH(CW)) u_nfwd (
        .clk_i(clk), .rst_n_i(rst_n), .flag_we_i(flag_we), .flag_wsel_i(flag_wsel),
        .z_flag_i(z), .s_flag_i(s), .c_flag_i(c), .ovr_flag_i(o),
        .instr_i(instr), .instr_valid_i(instr_valid), .fset_sel_i(fset_sel),
        .instr_ready_o(rdy0), .mask_o(mask0), .cond_o(cond0), .mask_valid_o(mv0),
        .mask_ready_i(mask_ready), .cnt_clr_i(cnt_clr), .eval_cnt_o(ev0), .taken_cnt_o(tk0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference condition table, written out case by case.
    function automatic logic mdl(input logic [3:0] cc, input logic [3:0] f);
        logic fz, fs, fc, fo, v;
        fz = f[3]; fs = f[2]; fc = f[1]; fo = f[0];
        v  = fo ^ fs;
        case (cc)
            4'h0: return 1'b1;
            4'h1: return fz | v;
            4'h2: return fc;
            4'h3: return fo;
            4'h4: return fs;
            4'h5: return fz;
            4'h6: return !(fs | fz);
            4'h7: return !v;
            4'h8: return 1'b0;
            4'h9: return !(fz | v);
            4'hA: return !fc;
            4'hB: return !fo;
            4'hC: return !fs;
            4'hD: return !fz;
            4'hE: return fs | fz;
            default: return v;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance model and DUT.
    task automatic tick();
        logic       acc;
        logic [3:0] f0, f1, cc;
        exp_t       e;
        #1;
        if (rst_n) begin
            chk("ready", 32'(rdy1), (q1.size() == 0) ? 32'd1 : 32'(mask_ready));
            chk("ready_nf", 32'(rdy0), (q0.size() == 0) ? 32'd1 : 32'(mask_ready));
            chk("valid", 32'(mv1), 32'(q1.size() != 0));
            chk("valid_nf", 32'(mv0), 32'(q0.size() != 0));
            if (q1.size() != 0) begin
                chk("mask", 32'(mask1), 32'(q1[0].m));
                chk("cond", 32'(cond1), 32'(q1[0].c));
            end
            if (q0.size() != 0) begin
                chk("mask_nf", 32'(mask0), 32'(q0[0].m));
                chk("cond_nf", 32'(cond0), 32'(q0[0].c));
            end
            chk("eval_cnt", 32'(ev1), 32'(me));
            chk("taken_cnt", 32'(tk1), 32'(mt1));
            chk("eval_cnt_nf", 32'(ev0), 32'(me));
            chk("taken_cnt_nf", 32'(tk0), 32'(mt0));

            acc = instr_valid && ((q1.size() == 0) || mask_ready);
            if ((q1.size() != 0) && mask_ready) begin
                q1.delete(0);
                q0.delete(0);
            end
            cc = instr[3:0];
            f0 = (fset_sel < 2'(NF)) ? mbank[fset_sel] : 4'h0;
            f1 = (flag_we && (flag_wsel == fset_sel)) ? {z, s, c, o} : f0;
            if (acc) begin
                e.c = cc;
                e.m = mdl(cc, f1); q1.push_back(e);
                e.m = mdl(cc, f0); q0.push_back(e);
            end
            if (cnt_clr) begin
                me = '0; mt1 = '0; mt0 = '0;
            end else if (acc) begin
                if (me != 4'hF) me++;
                if (mdl(cc, f1) && (mt1 != 4'hF)) mt1++;
                if (mdl(cc, f0) && (mt0 != 4'hF)) mt0++;
            end
            if (flag_we && (flag_wsel < 2'(NF))) mbank[flag_wsel] = {z, s, c, o};
        end else begin
            q1.delete();
            q0.delete();
            me = '0; mt1 = '0; mt0 = '0;
            for (int i = 0; i < NF; i++) mbank[i] = 4'h0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] cc, input logic [1:0] sel);
        instr       = {12'hA5C, cc};
        fset_sel    = sel;
        instr_valid = 1'b1;
    endtask

    task automatic wr_flags(input logic [1:0] sel, input logic [3:0] f);
        flag_we   = 1'b1;
        flag_wsel = sel;
        {z, s, c, o} = f;
    endtask

    initial begin
        rst_n = 1'b0; flag_we = 1'b0; flag_wsel = '0; {z, s, c, o} = 4'h0;
        instr = '0; instr_valid = 1'b0; fset_sel = '0; mask_ready = 1'b1; cnt_clr = 1'b0;
        me = '0; mt1 = '0; mt0 = '0;
        for (int i = 0; i < NF; i++) mbank[i] = 4'h0;

        // Reset, then every bank reads zero flags (including an unused select).
        tick(); tick();
        rst_n = 1'b1;
        set_instr(4'h5, 2'd0); tick();
        set_instr(4'hD, 2'd0); tick();
        set_instr(4'h5, 2'd1); tick();
        set_instr(4'hD, 2'd2); tick();
        set_instr(4'h5, 2'd3); tick();
        instr_valid = 1'b0; tick();

        // Full condition sweep against bank0 = Z only.
        wr_flags(2'd0, 4'b1000); tick();
        flag_we = 1'b0;
        for (int k = 0; k < 16; k++) begin
            set_instr(4'(k), 2'd0); tick();
        end
        instr_valid = 1'b0; tick();

        // Write to a nonexistent bank is ignored; that select still reads 0000.
        wr_flags(2'd3, 4'b1111); tick();
        flag_we = 1'b0;
        set_instr(4'hD, 2'd3); tick();
        set_instr(4'h5, 2'd0); tick();
        instr_valid = 1'b0; tick();

        // Bypass: write Z into bank1 while evaluating Z on bank1.
        wr_flags(2'd1, 4'b1000); set_instr(4'h5, 2'd1); tick();
        flag_we = 1'b0; tick();
        instr_valid = 1'b0; tick();

        // Backpressure: three instrs, consumer stalled four cycles.
        wr_flags(2'd0, 4'b0110); tick();
        flag_we = 1'b0; mask_ready = 1'b0;
        set_instr(4'h2, 2'd0); tick();
        set_instr(4'h4, 2'd0);
        repeat (4) tick();
        mask_ready = 1'b1; tick();
        set_instr(4'h7, 2'd0); tick();
        instr_valid = 1'b0; tick();
        tick();

        // Counters saturate, then clear beats a same-cycle accept.
        set_instr(4'h0, 2'd0);
        repeat (20) tick();
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0; instr_valid = 1'b0; tick();

        // Reset while a result is stalled.
        mask_ready = 1'b0;
        set_instr(4'h0, 2'd0); tick();
        instr_valid = 1'b0; tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        mask_ready = 1'b1; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
